// File: rtl/program_ram_ctrl.sv
// Program RAM controller: loader burn writes and fetch reads on one single-port RAM.
// Optional write read-back verification is enabled by defining PROG_RAM_WR_VERIFY_EN.
module program_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              ld_err,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  output logic              ram_aclr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic [8:0]        burn_cnt
);

`ifdef PROG_RAM_WR_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, RD, RWAIT, VRD, VWAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, RD, RWAIT} state_t;
`endif

  state_t     state;
  logic [1:0] wait_cnt;

  always_ff @(posedge clk) begin
    ram_aclr <= ~rst_n;
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ld_ack      <= 1'b0;
      ld_err      <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      ram_rden    <= 1'b0;
      busy        <= 1'b0;
      burn_cnt    <= '0;
    end else begin
      ld_ack   <= 1'b0;
      ld_err   <= 1'b0;
      if_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A port whose completion pulse is high this cycle is not re-accepted.
          if (ld_req && !ld_ack) begin
            state       <= WRITE;
            ram_address <= ld_addr;
            ram_data    <= ld_data;
            ram_wren    <= 1'b1;
            busy        <= 1'b1;
          end else if (if_req && !if_valid) begin
            state       <= RD;
            ram_address <= if_addr;
            ram_rden    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        WRITE: begin
          ram_wren <= 1'b0;
`ifdef PROG_RAM_WR_VERIFY_EN
          state    <= VRD;
          ram_rden <= 1'b1;
`else
          state    <= IDLE;
          busy     <= 1'b0;
          ld_ack   <= 1'b1;
          if (burn_cnt != 9'h1FF) burn_cnt <= burn_cnt + 9'd1;
`endif
        end
        RD: begin
          ram_rden <= 1'b0;
          wait_cnt <= 2'(RD_LAT - 1);
          state    <= RWAIT;
        end
        RWAIT: begin
          if (wait_cnt == 2'd0) begin
            if_instr <= ram_q;
            if_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
`ifdef PROG_RAM_WR_VERIFY_EN
        VRD: begin
          ram_rden <= 1'b0;
          wait_cnt <= 2'(RD_LAT - 1);
          state    <= VWAIT;
        end
        VWAIT: begin
          // ram_data still holds the captured write word for the compare.
          if (wait_cnt == 2'd0) begin
            ld_ack <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
            if (ram_q != ram_data) ld_err <= 1'b1;
            else if (burn_cnt != 9'h1FF) burn_cnt <= burn_cnt + 9'd1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_ram_ctrl.sv
// Directed bench: two controllers (RD_LAT=1 and RD_LAT=2) share stimulus, each with its own RAM model.
module tb_program_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        if_req [2];
  logic [7:0]  if_addr;
  logic        corrupt;

  logic        ld_ack [2];
  logic        ld_err [2];
  logic        if_valid [2];
  logic [15:0] if_instr [2];
  logic [7:0]  ram_address [2];
  logic [15:0] ram_data [2];
  logic        ram_wren [2];
  logic        ram_rden [2];
  logic        ram_aclr [2];
  logic [15:0] ram_q [2];
  logic        busy [2];
  logic [8:0]  burn_cnt [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic [15:0] mem [256];
    logic [15:0] q1, q2;

    program_ram_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(g + 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ack(ld_ack[g]), .ld_err(ld_err[g]),
      .if_req(if_req[g]), .if_addr(if_addr),
      .if_valid(if_valid[g]), .if_instr(if_instr[g]),
      .ram_address(ram_address[g]), .ram_data(ram_data[g]),
      .ram_wren(ram_wren[g]), .ram_rden(ram_rden[g]), .ram_aclr(ram_aclr[g]),
      .ram_q(ram_q[g]),
      .busy(busy[g]), .burn_cnt(burn_cnt[g])
    );

    always @(posedge clk) begin
      if (ram_wren[g]) mem[ram_address[g]] <= ram_data[g];
      if (ram_rden[g]) q1 <= mem[ram_address[g]];
      q2 <= q1;
    end
    assign ram_q[g] = ((g == 0) ? q1 : q2) ^ {15'd0, corrupt};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ack_lat(input int g);
`ifdef PROG_RAM_WR_VERIFY_EN
    return 4 + g;
`else
    return 2;
`endif
  endfunction

  task automatic burn(input logic [7:0] a, input logic [15:0] d, input logic exp_err);
    int wr_at [2], ack_at [2], acks [2];
    logic err [2];
    logic [7:0] wa [2];
    logic [15:0] wd [2];
    for (int g = 0; g < 2; g++) begin
      wr_at[g] = 0; ack_at[g] = 0; acks[g] = 0; err[g] = 1'bx; wa[g] = '0; wd[g] = '0;
    end
    @(posedge clk); #1 ld_req = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1 ld_req = 1'b0; ld_addr = ~a; ld_data = ~d;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (ram_wren[g] && wr_at[g] == 0) begin
          wr_at[g] = i; wa[g] = ram_address[g]; wd[g] = ram_data[g];
        end
        if (ld_ack[g]) begin
          acks[g]++;
          if (ack_at[g] == 0) begin ack_at[g] = i; err[g] = ld_err[g]; end
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("wren_cycle[%0d] @%0h", g, a), wr_at[g], 1);
      check_eq($sformatf("wr_addr[%0d] @%0h", g, a), {24'd0, wa[g]}, {24'd0, a});
      check_eq($sformatf("wr_data[%0d] @%0h", g, a), {16'd0, wd[g]}, {16'd0, d});
      check_eq($sformatf("ack_cycle[%0d] @%0h", g, a), ack_at[g], ack_lat(g));
      check_eq($sformatf("ack_pulses[%0d] @%0h", g, a), acks[g], 1);
      check_eq($sformatf("ld_err[%0d] @%0h", g, a), {31'd0, err[g]}, {31'd0, exp_err});
    end
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] d);
    int rd_at [2], val_at [2], vals [2];
    logic [15:0] got [2];
    for (int g = 0; g < 2; g++) begin
      rd_at[g] = 0; val_at[g] = 0; vals[g] = 0; got[g] = '0;
    end
    @(posedge clk); #1 if_req[0] = 1'b1; if_req[1] = 1'b1; if_addr = a;
    @(posedge clk); #1 if_req[0] = 1'b0; if_req[1] = 1'b0; if_addr = ~a;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (ram_rden[g] && rd_at[g] == 0) rd_at[g] = i;
        if (if_valid[g]) begin
          vals[g]++;
          if (val_at[g] == 0) begin val_at[g] = i; got[g] = if_instr[g]; end
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("rden_cycle[%0d] @%0h", g, a), rd_at[g], 1);
      check_eq($sformatf("valid_cycle[%0d] @%0h", g, a), val_at[g], 3 + g);
      check_eq($sformatf("valid_pulses[%0d] @%0h", g, a), vals[g], 1);
      check_eq($sformatf("if_instr[%0d] @%0h", g, a), {16'd0, got[g]}, {16'd0, d});
      check_eq($sformatf("if_instr_hold[%0d] @%0h", g, a), {16'd0, if_instr[g]}, {16'd0, d});
    end
  endtask

  initial begin
    int wr_at [2], ack_at [2], rd_at [2], val_at [2], vals [2];
    logic [15:0] got [2];

    rst_n = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    if_req[0] = 1'b0; if_req[1] = 1'b0; if_addr = '0; corrupt = 1'b0;

    // reset values
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("rst_outputs[%0d]", g),
               {1'b0, ld_ack[g], ld_err[g], if_valid[g], ram_wren[g], ram_rden[g], busy[g],
                burn_cnt[g], 16'(if_instr[g] | ram_data[g] | {8'd0, ram_address[g]})}, 32'd0);
      check_eq($sformatf("rst_aclr[%0d]", g), {31'd0, ram_aclr[g]}, 32'd1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("aclr_release[%0d]", g), {31'd0, ram_aclr[g]}, 32'd0);
      check_eq($sformatf("busy_release[%0d]", g), {31'd0, busy[g]}, 32'd0);
    end

    // burns
    burn(8'h00, 16'h2309, 1'b0);
    burn(8'h01, 16'h9C00, 1'b0);
    burn(8'h02, 16'hC000, 1'b0);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("burn_cnt3[%0d]", g), {23'd0, burn_cnt[g]}, 32'd3);
      check_eq($sformatf("idle_addr_hold[%0d]", g), {24'd0, ram_address[g]}, 32'h02);
      check_eq($sformatf("idle_data_hold[%0d]", g), {16'd0, ram_data[g]}, 32'hC000);
    end

    // fetches
    fetch(8'h00, 16'h2309);
    fetch(8'h01, 16'h9C00);
    fetch(8'h02, 16'hC000);

    // simultaneous write and fetch of the same address
    for (int g = 0; g < 2; g++) begin
      wr_at[g] = 0; ack_at[g] = 0; rd_at[g] = 0; val_at[g] = 0; vals[g] = 0; got[g] = '0;
    end
    @(posedge clk); #1 ld_req = 1'b1; ld_addr = 8'h05; ld_data = 16'h5A3C;
    if_req[0] = 1'b1; if_req[1] = 1'b1; if_addr = 8'h05;
    @(posedge clk); #1 ld_req = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (ram_wren[g] && wr_at[g] == 0) wr_at[g] = i;
        if (ld_ack[g] && ack_at[g] == 0) ack_at[g] = i;
        if (ram_rden[g] && rd_at[g] == 0 && ack_at[g] != 0) begin
          rd_at[g] = i; if_req[g] = 1'b0;
        end
        if (if_valid[g]) begin
          vals[g]++;
          if (val_at[g] == 0) begin val_at[g] = i; got[g] = if_instr[g]; end
        end
      end
    end
    if_req[0] = 1'b0; if_req[1] = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("both_wren[%0d]", g), wr_at[g], 1);
      check_eq($sformatf("both_ack[%0d]", g), ack_at[g], ack_lat(g));
      check_eq($sformatf("both_rden[%0d]", g), rd_at[g], ack_lat(g) + 1);
      check_eq($sformatf("both_valid[%0d]", g), val_at[g], ack_lat(g) + 3 + g);
      check_eq($sformatf("both_valid_pulses[%0d]", g), vals[g], 1);
      check_eq($sformatf("both_instr[%0d]", g), {16'd0, got[g]}, 32'h5A3C);
      check_eq($sformatf("burn_cnt4[%0d]", g), {23'd0, burn_cnt[g]}, 32'd4);
    end

    // reset during RWAIT drops the fetch
    @(posedge clk); #1 if_req[0] = 1'b1; if_req[1] = 1'b1; if_addr = 8'h01;
    @(posedge clk); #1 if_req[0] = 1'b0; if_req[1] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      vals[g] = 0;
      check_eq($sformatf("rwait_rst_busy[%0d]", g), {31'd0, busy[g]}, 32'd0);
      check_eq($sformatf("rwait_rst_cnt[%0d]", g), {23'd0, burn_cnt[g]}, 32'd0);
      check_eq($sformatf("rwait_rst_instr[%0d]", g), {16'd0, if_instr[g]}, 32'd0);
      check_eq($sformatf("rwait_rst_aclr[%0d]", g), {31'd0, ram_aclr[g]}, 32'd1);
      if (if_valid[g]) vals[g]++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) if (if_valid[g]) vals[g]++;
    end
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("rwait_rst_no_valid[%0d]", g), vals[g], 0);
      check_eq($sformatf("rwait_rst_aclr_off[%0d]", g), {31'd0, ram_aclr[g]}, 32'd0);
    end

`ifdef PROG_RAM_WR_VERIFY_EN
    corrupt = 1'b1;
    burn(8'h10, 16'h1234, 1'b1);
    for (int g = 0; g < 2; g++)
      check_eq($sformatf("verify_err_cnt[%0d]", g), {23'd0, burn_cnt[g]}, 32'd0);
    corrupt = 1'b0;
`endif
    burn(8'h10, 16'h1234, 1'b0);
    for (int g = 0; g < 2; g++)
      check_eq($sformatf("verify_ok_cnt[%0d]", g), {23'd0, burn_cnt[g]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
